// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci LFSR random source with runtime seed load, zero-seed
// substitution and an unbiased digit stream. Digits are drawn by rejection
// sampling over non-overlapping 4-bit windows of fresh feedback bits and are
// offered on a valid/ready handshake.
module lfsr_rng #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter logic [WIDTH-1:0] SEED       = 16'hBEEF,
    parameter int               DIGIT_BASE = 10
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rand_out,
    output logic [3:0]       digit,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             seed_zero,
    output logic [7:0]       reject_cnt
);

    // COLLECT gathers four fresh bits per candidate; HOLD offers an accepted digit.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam logic [4:0] BASE = 5'(DIGIT_BASE);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [1:0]       sc_q, sc_d;
    logic [3:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic [7:0]       rej_q, rej_d;

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [3:0]       candidate;

    // State register: every flop returns to its documented value on reset.
    // NOTE: non-blocking assignments here so all flops sample the same pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= COLLECT;
            lfsr_q  <= SEED;
            sc_q    <= 2'd0;
            digit_q <= 4'd0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            rej_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sc_q    <= sc_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            rej_q   <= rej_d;
        end
    end

    // Next-state logic: seed load overrides shifting, sampling and the handshake.
    always_comb begin
        fb        = ^(lfsr_q & TAPS);
        shifted   = {lfsr_q[WIDTH-2:0], fb};
        // After the 4th shift of a window the low nibble is entirely new feedback.
        candidate = shifted[3:0];

        // NOTE: every next-state signal defaults to its current value first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sc_d    = sc_q;
        digit_d = digit_q;
        valid_d = valid_q;
        zero_d  = zero_q;
        rej_d   = rej_q;

        if (seed_load) begin
            // A zero seed would lock the LFSR, so substitute the reset seed.
            lfsr_d  = (seed_in == '0) ? SEED : seed_in;
            zero_d  = (seed_in == '0);
            sc_d    = 2'd0;
            rej_d   = 8'd0;
            valid_d = 1'b0;
            state_d = COLLECT;
        end else begin
            if (en) begin
                lfsr_d = shifted;
            end
            unique case (state_q)
                COLLECT: begin
                    if (en) begin
                        if (sc_q == 2'd3) begin
                            sc_d = 2'd0;
                            if ({1'b0, candidate} < BASE) begin
                                digit_d = candidate;
                                valid_d = 1'b1;
                                state_d = HOLD;
                            end else if (rej_q != 8'hFF) begin
                                rej_d = rej_q + 8'd1;
                            end
                        end else begin
                            sc_d = sc_q + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    // The LFSR may keep shifting here, but no window is counted.
                    if (valid_q && digit_ready) begin
                        valid_d = 1'b0;
                        state_d = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // Outputs come straight from registers; no input reaches an output combinationally.
    always_comb begin
        rand_out    = lfsr_q;
        digit       = digit_q;
        digit_valid = valid_q;
        seed_zero   = zero_q;
        reject_cnt  = rej_q;
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: table-driven known-answer vectors, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_lfsr_rng;

    localparam int SEED_V = 'hBEEF;
    localparam int TAPS_V = 'hB400;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        en, seed_load, digit_ready;
    logic [15:0] seed_in;
    logic [15:0] rand_out;
    logic [3:0]  digit;
    logic        digit_valid, seed_zero;
    logic [7:0]  reject_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    lfsr_rng #(
        .WIDTH(16), .TAPS(16'hB400), .SEED(16'hBEEF), .DIGIT_BASE(10)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .en(en), .seed_load(seed_load),
        .seed_in(seed_in), .rand_out(rand_out), .digit(digit),
        .digit_valid(digit_valid), .digit_ready(digit_ready),
        .seed_zero(seed_zero), .reject_cnt(reject_cnt)
    );

    typedef struct {
        logic        ld;
        logic        en;
        logic        rdy;
        logic [15:0] seed;
        logic [15:0] e_rand;
        logic        e_valid;
        logic [3:0]  e_digit;
        logic [7:0]  e_rej;
        logic        e_zero;
    } vec_t;

    vec_t vecs[$];

    // ---------------- behavioural model ----------------
    int m_lfsr, m_shifts, m_digit, m_rej;
    bit m_valid, m_zero;

    function automatic int lfsr_next(int s);
        return ((s * 2) % 65536) + ($countones(s & TAPS_V) % 2);
    endfunction

    task automatic model_reset();
        m_lfsr = SEED_V; m_shifts = 0; m_digit = 0; m_rej = 0;
        m_valid = 0; m_zero = 0;
    endtask

    task automatic model_update(input bit ld, input bit e, input bit r, input int s);
        bit taking;
        int n;
        if (ld) begin
            m_lfsr = (s == 0) ? SEED_V : s;
            m_zero = (s == 0);
            m_shifts = 0; m_rej = 0; m_valid = 0;
        end else begin
            taking = m_valid && r;
            if (e) begin
                m_lfsr = lfsr_next(m_lfsr);
                if (!m_valid) begin
                    m_shifts++;
                    if (m_shifts == 4) begin
                        m_shifts = 0;
                        n = m_lfsr % 16;
                        if (n < 10) begin
                            m_digit = n; m_valid = 1;
                        end else if (m_rej < 255) begin
                            m_rej++;
                        end
                    end
                end
            end
            if (taking) m_valid = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_rand, input bit e_valid,
                             input int e_digit, input int e_rej, input bit e_zero);
        check({tag, ".rand"},  32'(rand_out),    32'(e_rand));
        check({tag, ".valid"}, 32'(digit_valid), 32'(e_valid));
        check({tag, ".digit"}, 32'(digit),       32'(e_digit));
        check({tag, ".rej"},   32'(reject_cnt),  32'(e_rej));
        check({tag, ".zero"},  32'(seed_zero),   32'(e_zero));
    endtask

    task automatic step(input logic ld, input logic e, input logic r, input logic [15:0] s);
        seed_load = ld; en = e; digit_ready = r; seed_in = s;
        @(posedge CLK);
        model_update(ld, e, r, int'(s));
        #1;
    endtask

    task automatic do_reset();
        seed_load = 0; en = 0; digit_ready = 0; seed_in = '0;
        RESET_N = 1'b0;
        model_reset();
        #7;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && !digit_valid; i++) step(0, 1, 0, 16'h0);
        check({tag, ".wait_valid"}, 32'(digit_valid), 32'd1);
    endtask

    function automatic vec_t mk(logic ld, logic e, logic r, logic [15:0] s, logic [15:0] er,
                                logic ev, logic [3:0] ed, logic [7:0] ej, logic ez);
        vec_t v;
        v.ld = ld; v.en = e; v.rdy = r; v.seed = s; v.e_rand = er;
        v.e_valid = ev; v.e_digit = ed; v.e_rej = ej; v.e_zero = ez;
        return v;
    endfunction

    task automatic apply_vecs(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step(vecs[i].ld, vecs[i].en, vecs[i].rdy, vecs[i].seed);
            check_all($sformatf("%s[%0d]", tag, i), vecs[i].e_rand, vecs[i].e_valid,
                      vecs[i].e_digit, vecs[i].e_rej, vecs[i].e_zero);
        end
    endtask

    initial begin
        // Known-answer sequence: free run from reset, then a rejecting seed.
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h7DDE, 0, 4'd0, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hFBBD, 0, 4'd0, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hF77B, 0, 4'd0, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hEEF6, 1, 4'd6, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hDDED, 1, 4'd6, 8'd0, 0));
        vecs.push_back(mk(1, 1, 0, 16'hC000, 16'hC000, 0, 4'd6, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h8001, 0, 4'd6, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0003, 0, 4'd6, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0006, 0, 4'd6, 8'd0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h000C, 0, 4'd6, 8'd1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0018, 0, 4'd6, 8'd1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0030, 0, 4'd6, 8'd1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0060, 0, 4'd6, 8'd1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h00C0, 1, 4'd0, 8'd1, 0));

        do_reset();
        check_all("reset", 'hBEEF, 0, 0, 0, 0);
        apply_vecs("kat", 0, vecs.size() - 1);

        // Zero seed is replaced by the reset seed and flagged.
        step(1, 0, 0, 16'h0000);
        check("zero_seed.rand", 32'(rand_out), 32'hBEEF);
        check("zero_seed.flag", 32'(seed_zero), 32'd1);
        step(1, 0, 0, 16'h1234);
        check("reload.rand", 32'(rand_out), 32'h1234);
        check("reload.flag", 32'(seed_zero), 32'd0);

        // Frozen when en=0 and no handshake/load.
        step(0, 0, 0, 16'h0);
        check("freeze.rand", 32'(rand_out), 32'h1234);

        // Handshake: valid falls next edge, cannot rise within 3 following shifts.
        wait_valid("hs");
        step(0, 1, 1, 16'h0);
        check("hs.fall", 32'(digit_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 0, 16'h0);
            check($sformatf("hs.gap%0d", k), 32'(digit_valid), 32'd0);
        end
        step(0, 1, 0, 16'h0);
        check("hs.fourth", 32'(digit_valid), 32'(m_valid));

        // Load priority over en and a pending transfer.
        wait_valid("prio");
        step(1, 1, 1, 16'h5A5A);
        check_all("prio", 'h5A5A, 0, m_digit, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 0, 16'h0);
            check($sformatf("prio.after%0d.valid", k), 32'(digit_valid), 32'(m_valid));
            check($sformatf("prio.after%0d.rand", k), 32'(rand_out), 32'(m_lfsr));
        end

        // Async reset in HOLD, between clock edges.
        do_reset();
        apply_vecs("kat_pre", 0, 4);
        #2;
        RESET_N = 1'b0;
        #1;
        check_all("async_rst", 'hBEEF, 0, 0, 0, 0);
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        check_all("post_rst", 'hBEEF, 0, 0, 0, 0);
        apply_vecs("kat_post", 0, 4);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            logic        ld, e, r;
            logic [15:0] s;
            ld = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            e  = ($urandom_range(0, 3) != 0);
            r  = 1'($urandom_range(0, 1));
            step(ld, e, r, s);
            check_all($sformatf("rnd[%0d]", c), m_lfsr, m_valid, m_digit, m_rej, m_zero);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
